traj_frame_sequencer: RTL and testbench
=======================================

// Module: traj_frame_sequencer
// PURPOSE
//  Per-frame controller feeding the ball-trajectory renderer. On each frame start it requests positions
//  for balls 0..num_balls-1 from the trajectory calculator over a valid/ready handshake, one request
//  outstanding at a time. Results go into a shadow buffer, which is committed to the renderer-facing
//  registers at the next frame start, so the renderer only sees stable, whole-frame positions.
// PARAMETERS
//  MAX_BALLS    7     number of position slots (num_balls_in <= MAX_BALLS)
//  TIME_W       12    width of the frame counter and of req_time_out
//  PHASE_STEP   40    frame offset between consecutive balls (req_time = frame_cnt + idx*PHASE_STEP)
//  OFF_X        2047  x coordinate written to unused slots (off-screen)
//  OFF_Y        1023  y coordinate written to unused slots (off-screen)
// PORTS
//  clk_in         in   1       pixel/system clock
//  rst_in         in   1       asynchronous, active-high reset
//  enable_in      in   1       sequencing enable
//  new_frame_in   in   1       1-cycle pulse at frame start
//  num_balls_in   in   3       ball count; sampled only on an accepted frame start
//  req_valid_out  out  1       request to the trajectory calculator
//  req_ready_in   in   1       calculator accepts the request
//  req_ball_out   out  3       ball index of the request
//  req_time_out   out  TIME_W  time of the request
//  resp_valid_in  in   1       response strobe; captured only in WAIT
//  resp_x_in      in   11      ball x
//  resp_y_in      in   10      ball y
//  traj_x_out     out  11 x7   committed x per slot
//  traj_y_out     out  10 x7   committed y per slot
//  traj_valid_out out  1       committed set is valid and num_balls > 0
//  busy_out       out  1       state is ISSUE or WAIT
//  overrun_out    out  1       1-cycle pulse: frame start arrived while busy
// BEHAVIOUR
//  Reset (async, any state):
//   - state=IDLE, frame_cnt=0, idx=0, pending=0, req_valid_out=0, traj_valid_out=0, overrun_out=0.
//   - All traj_x_out/traj_y_out and shadow slots = OFF_X/OFF_Y.
//  FSM states: IDLE, ISSUE, WAIT, DONE. Decisions use the registered state.
//  Frame start = new_frame_in && enable_in:
//   - frame_cnt += 1, wrapping mod 2^TIME_W.
//   - In IDLE or DONE:
//     - if pending: commit shadow -> active, traj_valid_out = (latched nb > 0), pending cleared.
//     - Latch nb = num_balls_in; preset every shadow slot with idx >= nb to OFF_X/OFF_Y.
//     - nb == 0: go to DONE with pending=1 (an empty set commits at the next frame start).
//     - otherwise: idx=0, go to ISSUE.
//   - In ISSUE or WAIT: overrun_out pulses; no commit, no restart; collection continues.
//  ISSUE: req_valid_out=1, req_ball_out=idx, req_time_out = frame_cnt + idx*PHASE_STEP (mod 2^TIME_W).
//   - Fields stay stable until req_ready_in; on ready, go to WAIT, req_valid_out=0 next cycle.
//  WAIT: on resp_valid_in, shadow[idx] <= {resp_x_in, resp_y_in}.
//   - idx == nb-1: go to DONE, pending=1; otherwise idx+1 and return to ISSUE.
//   - resp_valid_in outside WAIT is ignored.
//  Latency: positions requested in frame N become visible at frame start N+1, one cycle after the pulse.
//  Simultaneous events: a final response and new_frame_in in the same cycle -> response captured, overrun
//   pulses, commit waits for the next frame start.
//  enable_in low: new_frame_in is ignored and frame_cnt holds.
//   - ISSUE holds its request until it is accepted; WAIT completes its response.
//   - DONE/IDLE stay put; active outputs and traj_valid_out hold their last committed values.
//  num_balls_in > MAX_BALLS: clamped to MAX_BALLS at latch.
// STRUCTURE
//  juggle_pkg: MAX_BALLS, OFF_X/OFF_Y defaults, seq_state_t enum, pos_t struct {x[10:0], y[9:0]}.
//  Sub-module traj_pos_buffer: holds the shadow/active slot arrays.
//   - Ports: write-slot, preset-unused(nb), commit strobe.
//   - The FSM and frame counter stay in this module.
// TESTING
//  1. Reset, enable=1, nb=3, ready=1, response 2 cycles after each request:
//     - requests ball 0,1,2 with times 1,41,81.
//     - no output change until the next new_frame_in; then traj_x/y[0..2] = responses, slots 3..6 = 2047/1023,
//       traj_valid_out=1.
//  2. Backpressure: hold req_ready_in=0 for 10 cycles -> req_valid_out/req_ball_out/req_time_out stable;
//     exactly one request accepted.
//  3. Slow calculator: responses 100 cycles late so ISSUE/WAIT spans a frame start:
//     - overrun_out pulses once; old outputs held.
//     - commit happens at the following frame start.
//  4. nb=0 -> no requests; next frame start commits all slots to off-screen and traj_valid_out=0;
//     then nb=7 -> 7 requests, ball 6 at time frame_cnt+240.
//  5. Assert rst_in in WAIT mid-frame -> all outputs at reset values immediately.
//     - A late resp_valid_in is ignored; normal sequencing restarts on the next frame start.
//  6. Wrap: TIME_W=4 variant, frame_cnt=15, nb=2, PHASE_STEP=40 -> times 0 and 8;
//     enable low during a frame start -> frame_cnt holds.

Source files
------------

// File: rtl/traj_frame_sequencer_pkg.sv
// Shared constants and types for the ball-trajectory frame sequencer.
package traj_frame_sequencer_pkg;

   localparam int MAX_BALLS = 7;
   localparam int NB_W      = 3;
   localparam int X_W       = 11;
   localparam int Y_W       = 10;

   localparam logic [X_W-1:0]  OFF_X  = 11'd2047;
   localparam logic [Y_W-1:0]  OFF_Y  = 10'd1023;
   localparam logic [NB_W-1:0] MAX_NB = NB_W'(MAX_BALLS);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } seq_state_t;

   typedef struct packed {
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
   } pos_t;

   localparam pos_t OFF_POS = '{x: OFF_X, y: OFF_Y};

   function automatic logic [NB_W-1:0] clamp_nb(input logic [NB_W-1:0] nb);
      return (nb > MAX_NB) ? MAX_NB : nb;
   endfunction

endpackage

// File: rtl/traj_frame_sequencer_if.sv
// Request/response link between the frame sequencer and the trajectory calculator.
interface traj_frame_sequencer_if #(
   parameter int TIME_W = 12
);
   import traj_frame_sequencer_pkg::*;

   logic              req_valid_out;
   logic              req_ready_in;
   logic [NB_W-1:0]   req_ball_out;
   logic [TIME_W-1:0] req_time_out;
   logic              resp_valid_in;
   logic [X_W-1:0]    resp_x_in;
   logic [Y_W-1:0]    resp_y_in;

   modport master (
      output req_valid_out,
      output req_ball_out,
      output req_time_out,
      input  req_ready_in,
      input  resp_valid_in,
      input  resp_x_in,
      input  resp_y_in
   );

   modport slave (
      input  req_valid_out,
      input  req_ball_out,
      input  req_time_out,
      output req_ready_in,
      output resp_valid_in,
      output resp_x_in,
      output resp_y_in
   );

endinterface

// File: rtl/traj_pos_buffer.sv
// Shadow/active position slots: the shadow set fills during a frame and a commit
// copies it in one step to the renderer-facing active set.
module traj_pos_buffer
   import traj_frame_sequencer_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 wr_en_i,
   input  logic [NB_W-1:0]      wr_idx_i,
   input  pos_t                 wr_pos_i,
   input  logic                 preset_en_i,
   input  logic [NB_W-1:0]      preset_nb_i,
   input  logic                 commit_i,
   output pos_t [MAX_BALLS-1:0] active_o
);

   pos_t [MAX_BALLS-1:0] shadow_q, shadow_d;
   pos_t [MAX_BALLS-1:0] active_q, active_d;

   // Commit reads the old shadow, so a preset in the same cycle only affects the next frame.
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      if (commit_i) begin
         active_d = shadow_q;
      end
      for (int i = 0; i < MAX_BALLS; i++) begin
         if (preset_en_i && (NB_W'(i) >= preset_nb_i)) begin
            shadow_d[i] = OFF_POS;
         end
      end
      if (wr_en_i && (wr_idx_i < MAX_NB)) begin
         shadow_d[wr_idx_i] = wr_pos_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         shadow_q <= {MAX_BALLS{OFF_POS}};
         active_q <= {MAX_BALLS{OFF_POS}};
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
      end
   end

   assign active_o = active_q;

endmodule

// File: rtl/traj_frame_sequencer.sv
// Per-frame sequencer: requests one position per ball from the calculator (one outstanding),
// collects them in a shadow set and commits that set to the renderer at the next frame start.
module traj_frame_sequencer
   import traj_frame_sequencer_pkg::*;
#(
   parameter int TIME_W     = 12,
   parameter int PHASE_STEP = 40
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic                          enable_in,
   input  logic                          new_frame_in,
   input  logic [NB_W-1:0]               num_balls_in,
   traj_frame_sequencer_if.master        calc,
   output logic [MAX_BALLS-1:0][X_W-1:0] traj_x_out,
   output logic [MAX_BALLS-1:0][Y_W-1:0] traj_y_out,
   output logic                          traj_valid_out,
   output logic                          busy_out,
   output logic                          overrun_out
);

   localparam logic [TIME_W-1:0] STEP_T = TIME_W'(PHASE_STEP);

   seq_state_t        state_q, state_d;
   logic [TIME_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [TIME_W-1:0] req_time_q, req_time_d;
   logic [NB_W-1:0]   idx_q, idx_d;
   logic [NB_W-1:0]   nb_q, nb_d;
   logic              pending_q, pending_d;
   logic              valid_q, valid_d;
   logic              overrun_q, overrun_d;

   logic                 frame_start;
   logic                 busy;
   logic                 commit;
   logic                 preset_en;
   logic                 wr_en;
   pos_t                 wr_pos;
   pos_t [MAX_BALLS-1:0] active;

   function automatic logic [TIME_W-1:0] req_time_f(input logic [TIME_W-1:0] cnt,
                                                    input logic [NB_W-1:0]   idx);
      return cnt + TIME_W'(idx) * STEP_T;
   endfunction

   assign frame_start = new_frame_in && enable_in;
   assign busy        = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
   assign wr_pos      = '{x: calc.resp_x_in, y: calc.resp_y_in};

   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      req_time_d  = req_time_q;
      idx_d       = idx_q;
      nb_d        = nb_q;
      pending_d   = pending_q;
      valid_d     = valid_q;
      overrun_d   = frame_start && busy;
      commit      = 1'b0;
      preset_en   = 1'b0;
      wr_en       = 1'b0;

      if (frame_start) begin
         frame_cnt_d = frame_cnt_q + TIME_W'(1);
      end

      case (state_q)
         ST_ISSUE: begin
            if (calc.req_ready_in) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (calc.resp_valid_in) begin
               wr_en = 1'b1;
               if (idx_q == nb_q - NB_W'(1)) begin
                  state_d   = ST_DONE;
                  pending_d = 1'b1;
               end else begin
                  idx_d      = idx_q + NB_W'(1);
                  state_d    = ST_ISSUE;
                  req_time_d = req_time_f(frame_cnt_d, idx_d);
               end
            end
         end
         default: begin
            // Request time is frozen on entry to ISSUE so an overrun frame cannot disturb it.
            if (frame_start) begin
               if (pending_q) begin
                  commit    = 1'b1;
                  valid_d   = (nb_q != '0);
                  pending_d = 1'b0;
               end
               nb_d      = clamp_nb(num_balls_in);
               preset_en = 1'b1;
               if (nb_d == '0) begin
                  state_d   = ST_DONE;
                  pending_d = 1'b1;
               end else begin
                  idx_d      = '0;
                  state_d    = ST_ISSUE;
                  req_time_d = req_time_f(frame_cnt_d, '0);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= ST_IDLE;
         frame_cnt_q <= '0;
         req_time_q  <= '0;
         idx_q       <= '0;
         nb_q        <= '0;
         pending_q   <= 1'b0;
         valid_q     <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         req_time_q  <= req_time_d;
         idx_q       <= idx_d;
         nb_q        <= nb_d;
         pending_q   <= pending_d;
         valid_q     <= valid_d;
         overrun_q   <= overrun_d;
      end
   end

   traj_pos_buffer u_buf (
      .clk_i       (clk_in),
      .rst_i       (rst_in),
      .wr_en_i     (wr_en),
      .wr_idx_i    (idx_q),
      .wr_pos_i    (wr_pos),
      .preset_en_i (preset_en),
      .preset_nb_i (nb_d),
      .commit_i    (commit),
      .active_o    (active)
   );

   always_comb begin
      for (int i = 0; i < MAX_BALLS; i++) begin
         traj_x_out[i] = active[i].x;
         traj_y_out[i] = active[i].y;
      end
   end

   assign calc.req_valid_out = (state_q == ST_ISSUE);
   assign calc.req_ball_out  = idx_q;
   assign calc.req_time_out  = req_time_q;
   assign traj_valid_out     = valid_q;
   assign busy_out           = busy;
   assign overrun_out        = overrun_q;

endmodule

// File: tb/tb_traj_frame_sequencer.sv
// Bench for traj_frame_sequencer: a randomized calculator responder and a frame-level
// reference model on the default instance, plus a directed wrap check on a 4-bit-time instance.
module tb_traj_frame_sequencer;

   localparam int OFFX = 2047;
   localparam int OFFY = 1023;

   logic clk_in = 1'b0;
   logic rst_in;
   logic enable_in, new_frame_in;
   logic [2:0] num_balls_in;
   logic [6:0][10:0] traj_x_out;
   logic [6:0][9:0]  traj_y_out;
   logic traj_valid_out, busy_out, overrun_out;

   logic en2, nf2;
   logic [2:0] nb2;
   logic [6:0][10:0] tx2;
   logic [6:0][9:0]  ty2;
   logic tv2, busy2, ovr2;

   traj_frame_sequencer_if #(.TIME_W(12)) calc ();
   traj_frame_sequencer_if #(.TIME_W(4))  calc4 ();

   traj_frame_sequencer #(.TIME_W(12), .PHASE_STEP(40)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in), .new_frame_in(new_frame_in),
      .num_balls_in(num_balls_in), .calc(calc), .traj_x_out(traj_x_out), .traj_y_out(traj_y_out),
      .traj_valid_out(traj_valid_out), .busy_out(busy_out), .overrun_out(overrun_out));

   traj_frame_sequencer #(.TIME_W(4), .PHASE_STEP(40)) dut4 (
      .clk_in(clk_in), .rst_in(rst_in), .enable_in(en2), .new_frame_in(nf2),
      .num_balls_in(nb2), .calc(calc4), .traj_x_out(tx2), .traj_y_out(ty2),
      .traj_valid_out(tv2), .busy_out(busy2), .overrun_out(ovr2));

   always #5 clk_in = ~clk_in;

   int n_asserts = 0;
   int n_fail    = 0;

   // Reference model: frame-level view of collection, shadow set and committed set.
   bit m_collect, m_wait, m_pend, m_val, m_ovr;
   int m_idx, m_nb, m_cnt, m_req_time;
   int m_sx[7], m_sy[7], m_ax[7], m_ay[7];

   // Calculator responder state and knobs.
   bit cal_wait;
   int cal_cnt, cal_hold;
   int rdy_pct = 100, hold_first = 0, resp_delay = 2, noise_pct = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_asserts++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_collect = 0; m_wait = 0; m_pend = 0; m_val = 0; m_ovr = 0;
      m_idx = 0; m_nb = 0; m_cnt = 0; m_req_time = 0;
      for (int i = 0; i < 7; i++) begin
         m_sx[i] = OFFX; m_sy[i] = OFFY; m_ax[i] = OFFX; m_ay[i] = OFFY;
      end
   endtask

   task automatic check_outputs();
      check("busy", busy_out, m_collect);
      check("overrun", overrun_out, m_ovr);
      check("req_valid", calc.req_valid_out, m_collect && !m_wait);
      if (m_collect && !m_wait) begin
         check("req_ball", calc.req_ball_out, m_idx);
         check("req_time", calc.req_time_out, m_req_time);
      end
      check("traj_valid", traj_valid_out, m_val);
      for (int i = 0; i < 7; i++) begin
         check($sformatf("traj_x[%0d]", i), traj_x_out[i], m_ax[i]);
         check($sformatf("traj_y[%0d]", i), traj_y_out[i], m_ay[i]);
      end
   endtask

   task automatic cycle(input bit nf);
      bit rdy, rv, fs;
      int rx, ry;
      rv = 0;
      rx = int'($urandom_range(2047));
      ry = int'($urandom_range(1023));
      if (cal_wait) begin
         if (cal_cnt <= 0) begin rv = 1; cal_wait = 0; end
         else cal_cnt--;
      end else if ($urandom_range(99) < noise_pct) begin
         rv = 1;
      end
      rdy = 0;
      if (calc.req_valid_out === 1'b1) begin
         rdy = (cal_hold >= hold_first) && ($urandom_range(99) < rdy_pct);
         cal_hold++;
         if (rdy) begin cal_wait = 1; cal_cnt = resp_delay - 1; cal_hold = 0; end
      end
      new_frame_in       = nf;
      calc.req_ready_in  = rdy;
      calc.resp_valid_in = rv;
      calc.resp_x_in     = 11'(rx);
      calc.resp_y_in     = 10'(ry);

      fs    = nf && enable_in;
      m_ovr = fs && m_collect;
      if (fs) m_cnt = (m_cnt + 1) % 4096;
      if (m_collect) begin
         if (!m_wait) begin
            if (rdy) m_wait = 1;
         end else if (rv) begin
            m_sx[m_idx] = rx; m_sy[m_idx] = ry;
            m_wait = 0;
            if (m_idx == m_nb - 1) begin
               m_collect = 0; m_pend = 1;
            end else begin
               m_idx++;
               m_req_time = (m_cnt + m_idx * 40) % 4096;
            end
         end
      end else if (fs) begin
         if (m_pend) begin
            for (int i = 0; i < 7; i++) begin m_ax[i] = m_sx[i]; m_ay[i] = m_sy[i]; end
            m_val  = (m_nb > 0);
            m_pend = 0;
         end
         m_nb = (int'(num_balls_in) > 7) ? 7 : int'(num_balls_in);
         for (int i = m_nb; i < 7; i++) begin m_sx[i] = OFFX; m_sy[i] = OFFY; end
         if (m_nb == 0) m_pend = 1;
         else begin m_collect = 1; m_wait = 0; m_idx = 0; m_req_time = m_cnt; end
      end

      @(posedge clk_in); #1;
      check_outputs();
   endtask

   task automatic run_frame(input int nb, input int len);
      num_balls_in = 3'(nb);
      cycle(1'b1);
      num_balls_in = 3'($urandom_range(7));
      repeat (len - 1) cycle(1'b0);
   endtask

   task automatic tick2();
      @(posedge clk_in); #1;
   endtask

   initial begin
      rst_in = 1; enable_in = 0; new_frame_in = 0; num_balls_in = 0;
      calc.req_ready_in = 0; calc.resp_valid_in = 0; calc.resp_x_in = 0; calc.resp_y_in = 0;
      en2 = 0; nf2 = 0; nb2 = 0;
      calc4.req_ready_in = 0; calc4.resp_valid_in = 0; calc4.resp_x_in = 0; calc4.resp_y_in = 0;
      cal_wait = 0; cal_cnt = 0; cal_hold = 0;
      model_reset();

      #1;
      check_outputs();
      check("w4_reset_valid", tv2, 0);
      check("w4_reset_x0", tx2[0], OFFX);
      repeat (2) @(posedge clk_in);
      #1 rst_in = 0;
      enable_in = 1;

      // Basic three-ball frames, then backpressure on each request.
      run_frame(3, 30);
      run_frame(3, 30);
      hold_first = 10;
      run_frame(2, 60);
      run_frame(1, 40);
      hold_first = 0;

      // Slow calculator spanning several frame starts.
      resp_delay = 100;
      repeat (4) run_frame(2, 70);
      resp_delay = 2;
      repeat (250) cycle(1'b0);

      // Empty frame, then a full seven-ball frame.
      run_frame(0, 20);
      run_frame(7, 60);
      run_frame(0, 20);
      run_frame(3, 30);

      // Reset asserted while waiting for a response; its late response must be ignored.
      resp_delay = 20;
      num_balls_in = 3'd3;
      cycle(1'b1);
      for (int k = 0; k < 50 && !m_wait; k++) cycle(1'b0);
      check("reach_wait", m_wait, 1);
      repeat (3) cycle(1'b0);
      #2 rst_in = 1;
      model_reset();
      #1;
      check_outputs();
      @(posedge clk_in); #1;
      rst_in = 0;
      resp_delay = 2;
      repeat (30) cycle(1'b0);
      run_frame(3, 30);
      run_frame(0, 20);

      // Randomized frames: random ball count, enable, ready, latency and stray responses.
      rdy_pct = 60; noise_pct = 20;
      for (int f = 0; f < 40; f++) begin
         enable_in  = ($urandom_range(3) != 0);
         resp_delay = int'($urandom_range(1, 8));
         run_frame(int'($urandom_range(7)), int'($urandom_range(15, 60)));
      end
      enable_in = 1; noise_pct = 0; rdy_pct = 100; resp_delay = 2;
      repeat (120) cycle(1'b0);
      run_frame(2, 30);

      // 4-bit time instance: counter wrap and enable-low frame start.
      new_frame_in = 0; calc.req_ready_in = 0; calc.resp_valid_in = 0;
      en2 = 1; nb2 = 0;
      repeat (15) begin nf2 = 1; tick2(); nf2 = 0; tick2(); end
      en2 = 0; nf2 = 1; tick2(); nf2 = 0; tick2();
      check("w4_idle_busy", busy2, 0);
      check("w4_idle_overrun", ovr2, 0);
      en2 = 1; nb2 = 3'd2; nf2 = 1; tick2(); nf2 = 0; nb2 = 3'd5;
      check("w4_req0_valid", calc4.req_valid_out, 1);
      check("w4_req0_ball", calc4.req_ball_out, 0);
      check("w4_req0_time", calc4.req_time_out, 0);
      check("w4_empty_commit", tv2, 0);
      calc4.req_ready_in = 1; tick2(); calc4.req_ready_in = 0;
      check("w4_wait", calc4.req_valid_out, 0);
      calc4.resp_valid_in = 1; calc4.resp_x_in = 11'd100; calc4.resp_y_in = 10'd200;
      tick2(); calc4.resp_valid_in = 0;
      check("w4_req1_valid", calc4.req_valid_out, 1);
      check("w4_req1_ball", calc4.req_ball_out, 1);
      check("w4_req1_time", calc4.req_time_out, 8);
      calc4.req_ready_in = 1; tick2(); calc4.req_ready_in = 0;
      calc4.resp_valid_in = 1; calc4.resp_x_in = 11'd300; calc4.resp_y_in = 10'd400;
      tick2(); calc4.resp_valid_in = 0;
      check("w4_done_busy", busy2, 0);
      check("w4_precommit_valid", tv2, 0);
      check("w4_precommit_x0", tx2[0], OFFX);
      nf2 = 1; tick2(); nf2 = 0;
      check("w4_commit_valid", tv2, 1);
      check("w4_commit_x0", tx2[0], 100);
      check("w4_commit_y0", ty2[0], 200);
      check("w4_commit_x1", tx2[1], 300);
      check("w4_commit_y1", ty2[1], 400);
      check("w4_commit_x2", tx2[2], OFFX);
      check("w4_commit_y6", ty2[6], OFFY);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
